// File: rtl/matmul_pkg.sv
// Shared constants, FSM state type and element slicing helper for the
// 4x4 matrix multiplier operand driver.
package matmul_pkg;

    localparam int ELEM_W = 16;
    localparam int DIM    = 4;
    localparam int NELEM  = DIM * DIM;
    localparam int BUS_W  = ELEM_W * NELEM;
    localparam int CNT_W  = $clog2(NELEM);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        SEND_A,
        LOAD_B,
        SEND_B,
        WAIT_RES,
        DRAIN
    } state_t;

    // Row-major element n = DIM*i + j lives at bits [ELEM_W*n +: ELEM_W].
    function automatic logic [ELEM_W-1:0] elem_slice(input logic [BUS_W-1:0] word,
                                                     input logic [CNT_W-1:0] n);
        return word[int'(n)*ELEM_W +: ELEM_W];
    endfunction

endpackage

// File: rtl/matmul_elem_serializer.sv
// Captures one 256-bit product word and replays it as a valid/ready stream of
// 16 row-major elements, flagging the last one.
module matmul_elem_serializer
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [BUS_W-1:0]  word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ELEM_W-1:0] out_data,
    output logic              out_last,
    output logic              done
);

    logic [BUS_W-1:0] capReg;
    logic [CNT_W-1:0] idx;
    logic             active;
    logic             fire;

    // Index only moves on a handshake, so data and last hold during stalls.
    assign fire      = active && out_ready;
    assign out_valid = active;
    assign out_data  = elem_slice(capReg, idx);
    assign out_last  = active && (idx == CNT_W'(NELEM - 1));
    assign done      = fire && out_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            capReg <= '0;
            idx    <= '0;
            active <= 1'b0;
        end else if (load) begin
            capReg <= word;
            idx    <= '0;
            active <= 1'b1;
        end else if (fire) begin
            idx <= idx + 1'b1;
            if (out_last) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/matmul_operand_driver.sv
// Streams operands A and B into the change-triggered 4x4 multiplier as whole
// bus words, waits for its result flag, and streams the product back out.
module matmul_operand_driver
    import matmul_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ELEM_W-1:0] in_data,
    output logic [BUS_W-1:0]  bus_out,
    input  logic [BUS_W-1:0]  res_in,
    input  logic              res_flag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ELEM_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              err_nochg,
    output logic              err_timeout
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t           state;
    state_t           nextState;
    logic [CNT_W-1:0] elemCnt;
    logic [BUS_W-1:0] opWord;
    logic [TMO_W-1:0] tmoCnt;

    logic accept;
    logic sendWord;
    logic setNoChg;
    logic setTimeout;
    logic clearErr;
    logic capture;
    logic tmoStep;
    logic drainDone;
    logic wordSame;

    assign busy     = (state != IDLE);
    assign wordSame = (opWord == bus_out);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        nextState  = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        sendWord   = 1'b0;
        setNoChg   = 1'b0;
        setTimeout = 1'b0;
        clearErr   = 1'b0;
        capture    = 1'b0;
        tmoStep    = 1'b0;

        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    nextState = LOAD_A;
                    clearErr  = 1'b1;
                end
            end
            LOAD_A, LOAD_B: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid && (elemCnt == CNT_W'(NELEM - 1))) begin
                    nextState = (state == LOAD_A) ? SEND_A : SEND_B;
                end
            end
            SEND_A, SEND_B: begin
                // An unchanged word would never trigger the multiplier.
                if (wordSame) begin
                    setNoChg  = 1'b1;
                    nextState = IDLE;
                end else begin
                    sendWord  = 1'b1;
                    nextState = (state == SEND_A) ? LOAD_B : WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (res_flag) begin
                    capture   = 1'b1;
                    nextState = DRAIN;
                end else if (tmoCnt == TMO_W'(TIMEOUT - 1)) begin
                    setTimeout = 1'b1;
                    nextState  = IDLE;
                end else begin
                    tmoStep = 1'b1;
                end
            end
            DRAIN: begin
                // A waiting next job starts on the same edge as the last output.
                if (drainDone) begin
                    if (in_valid) begin
                        nextState = LOAD_A;
                        clearErr  = 1'b1;
                    end else begin
                        nextState = IDLE;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // NOTE: the assembly word is reset with everything else so the first
    // no-change comparison never sees X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elemCnt     <= '0;
            opWord      <= '0;
            bus_out     <= '0;
            tmoCnt      <= '0;
            err_nochg   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (accept) begin
                opWord[int'(elemCnt)*ELEM_W +: ELEM_W] <= in_data;
                elemCnt <= elemCnt + 1'b1;
            end
            if (sendWord) begin
                bus_out <= opWord;
            end
            tmoCnt <= tmoStep ? tmoCnt + 1'b1 : '0;
            if (clearErr) begin
                err_nochg   <= 1'b0;
                err_timeout <= 1'b0;
            end
            if (setNoChg) begin
                err_nochg <= 1'b1;
            end
            if (setTimeout) begin
                err_timeout <= 1'b1;
            end
        end
    end

    matmul_elem_serializer uSerializer (
        .clk       (clk),
        .rst       (rst),
        .load      (capture),
        .word      (res_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (drainDone)
    );

endmodule

// File: tb/tb_matmul_operand_driver.sv
// Directed and randomized bench for matmul_operand_driver with a behavioural
// multiplier model and a matrix-arithmetic reference.
module tb_matmul_operand_driver;
    import matmul_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ELEM_W-1:0] in_data = '0;
    logic [BUS_W-1:0]  bus_out;
    logic [BUS_W-1:0]  res_in = '0;
    logic              res_flag = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ELEM_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              err_nochg;
    logic              err_timeout;

    int checks = 0;
    int errors = 0;

    logic [BUS_W-1:0] opA;
    logic [BUS_W-1:0] opB;

    // Multiplier model state
    logic [BUS_W-1:0] mdlPrev = '0;
    logic [BUS_W-1:0] mdlLast = '0;
    int               mdlSeen = 0;
    logic             mdlHoldLow = 1'b0;

    matmul_operand_driver dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .bus_out     (bus_out),
        .res_in      (res_in),
        .res_flag    (res_flag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .err_nochg   (err_nochg),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // C = A x B over 16-bit elements, row-major packing, truncated to 16 bits.
    function automatic logic [BUS_W-1:0] matProd(input logic [BUS_W-1:0] a,
                                                 input logic [BUS_W-1:0] b);
        logic [BUS_W-1:0] c;
        logic [15:0]      acc;
        c = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = '0;
                for (int k = 0; k < 4; k++) begin
                    acc = acc + 16'(a[16*(4*i+k) +: 16] * b[16*(4*k+j) +: 16]);
                end
                c[16*(4*i+j) +: 16] = acc;
            end
        end
        return c;
    endfunction

    // Multiplier model: the second bus change of a job is B; its product and
    // flag are ready for the edge ending the first WAIT_RES cycle.
    always @(negedge clk) begin
        if (bus_out !== mdlLast) begin
            mdlPrev = mdlLast;
            mdlLast = bus_out;
            mdlSeen = mdlSeen + 1;
            if (mdlSeen == 2 && !mdlHoldLow) begin
                res_in   = matProd(mdlPrev, mdlLast);
                res_flag = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [BUS_W-1:0] obs,
                         input logic [BUS_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        mdlSeen  = 0;
        mdlLast  = bus_out;
        mdlPrev  = bus_out;
        res_flag = 1'b0;
        res_in   = '0;
    endtask

    task automatic randomOps();
        for (int n = 0; n < NELEM; n++) begin
            opA[16*n +: 16] = 16'($urandom);
            opB[16*n +: 16] = 16'($urandom);
        end
        opA[0] = 1'b1;
    endtask

    // Presents the first n stream elements (A then B); returns at the negedge
    // where the last of them is driven and will be accepted.
    task automatic feed(input int n);
        int idx = 0;
        int guard = 0;
        while (idx < n && guard < 200) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = (idx < NELEM) ? opA[16*idx +: 16] : opB[16*(idx-NELEM) +: 16];
            if (in_ready) idx++;
            guard++;
        end
        check("feed_accepted", BUS_W'(idx), BUS_W'(n));
    endtask

    function automatic logic readyFor(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
            default: return 1'b1 & 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic drain(input logic [BUS_W-1:0] expWord, input int mode, input string name);
        int          k = 0;
        int          cyc = 0;
        logic        stalled = 1'b0;
        logic [15:0] held = '0;
        while (k < NELEM && cyc < 400) begin
            if (stalled) begin
                check({name, "_stall_valid"}, BUS_W'(out_valid), BUS_W'(1));
                check({name, "_stall_data"}, BUS_W'(out_data), BUS_W'(held));
            end
            out_ready = readyFor(mode, cyc);
            if (out_valid && out_ready) begin
                check({name, "_data"}, BUS_W'(out_data), BUS_W'(expWord[16*k +: 16]));
                check({name, "_last"}, BUS_W'(out_last), BUS_W'(k == NELEM - 1));
                k++;
                stalled = 1'b0;
            end else if (out_valid) begin
                stalled = 1'b1;
                held    = out_data;
            end
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check({name, "_count"}, BUS_W'(k), BUS_W'(NELEM));
        check({name, "_valid_after"}, BUS_W'(out_valid), BUS_W'(0));
        check({name, "_busy_after"}, BUS_W'(busy), BUS_W'(0));
    endtask

    task automatic runJob(input int mode, input string name);
        int lat = 0;
        resetModel();
        feed(2 * NELEM);
        @(negedge clk);
        in_valid = 1'b0;
        check({name, "_errs_clear"}, BUS_W'({err_nochg, err_timeout}), BUS_W'(0));
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, BUS_W'(lat), BUS_W'(2));
        drain(matProd(opA, opB), mode, name);
        check({name, "_bus_holds_b"}, bus_out, opB);
    endtask

    initial begin
        int   waitCyc;
        logic sawValid;
        logic earlyTmo;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_bus", bus_out, '0);
        check("rst_ctrl", BUS_W'({in_ready, out_valid, out_last, busy, err_nochg, err_timeout}), '0);
        check("rst_data", BUS_W'(out_data), '0);
        rst = 1'b0;

        // All-zero A right after reset matches the idle bus
        opA = '0;
        opB = '0;
        resetModel();
        feed(NELEM);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("nochg_flag", BUS_W'(err_nochg), BUS_W'(1));
        check("nochg_idle", BUS_W'(busy), BUS_W'(0));
        check("nochg_bus", bus_out, '0);
        check("nochg_novalid", BUS_W'(out_valid), BUS_W'(0));

        // Identity x 1..16
        for (int n = 0; n < NELEM; n++) begin
            opA[16*n +: 16] = ((n / 4) == (n % 4)) ? 16'd1 : 16'd0;
            opB[16*n +: 16] = 16'(n + 1);
        end
        runJob(0, "ident");

        // All ones x all twos, then the same job with a stalling sink
        for (int n = 0; n < NELEM; n++) begin
            opA[16*n +: 16] = 16'd1;
            opB[16*n +: 16] = 16'd2;
        end
        runJob(0, "ones");
        runJob(1, "ones_stall");

        for (int r = 0; r < 3; r++) begin
            randomOps();
            runJob(2, "rand");
        end

        // Flag never rises: timeout after TIMEOUT waiting cycles
        randomOps();
        resetModel();
        mdlHoldLow = 1'b1;
        feed(2 * NELEM);
        @(negedge clk);
        in_valid = 1'b0;
        waitCyc  = 0;
        sawValid = 1'b0;
        earlyTmo = 1'b0;
        while (busy && waitCyc < 40) begin
            @(negedge clk);
            if (out_valid) sawValid = 1'b1;
            if (busy) begin
                waitCyc++;
                if (err_timeout) earlyTmo = 1'b1;
            end
        end
        check("tmo_cycles", BUS_W'(waitCyc), BUS_W'(15));
        check("tmo_flag", BUS_W'(err_timeout), BUS_W'(1));
        check("tmo_early", BUS_W'(earlyTmo), BUS_W'(0));
        check("tmo_novalid", BUS_W'(sawValid), BUS_W'(0));
        check("tmo_nochg", BUS_W'(err_nochg), BUS_W'(0));
        mdlHoldLow = 1'b0;

        // Reset while the fifth element of B is presented
        randomOps();
        resetModel();
        feed(NELEM + 4);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = opB[16*4 +: 16];
        rst      = 1'b1;
        #1;
        check("midrst_bus", bus_out, '0);
        check("midrst_ctrl", BUS_W'({in_ready, out_valid, out_last, busy, err_nochg, err_timeout}), '0);
        check("midrst_data", BUS_W'(out_data), '0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        randomOps();
        runJob(2, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
